// File: rtl/muldiv_sequencer_if.sv
// Handshake/operand bundle between the EX stage and the RV32M multi-cycle unit.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, func3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, func3_i, op_a_i, op_b_i, flush_i,
        output busy_o, stall_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply (shift-add) / restoring divide unit with start/done handshake.
// Optional macro MULDIV_FAST_MUL_EN: all multiplies complete through a single-cycle multiplier.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic clk,
    input logic rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] hi, lo, m, result_q;
    logic            neg_q, neg_r;

    logic            is_div, sgn_a, sgn_b, sa, sb, div_zero, div_ovf, fast_mul;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [2*XLEN-1:0] fast_prod;

    always_comb begin
        is_div   = bus.func3_i[2];
        sgn_a    = is_div ? ~bus.func3_i[0] : (bus.func3_i[1:0] != 2'b11);
        sgn_b    = is_div ? ~bus.func3_i[0] : ~bus.func3_i[1];
        sa       = sgn_a & bus.op_a_i[XLEN-1];
        sb       = sgn_b & bus.op_b_i[XLEN-1];
        a_abs    = sa ? ('0 - bus.op_a_i) : bus.op_a_i;
        b_abs    = sb ? ('0 - bus.op_b_i) : bus.op_b_i;
        div_zero = is_div & (bus.op_b_i == '0);
        div_ovf  = is_div & ~bus.func3_i[0] & (bus.op_b_i == '1)
                 & (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}});
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended to 2*XLEN: the low 2*XLEN bits equal the 33x33 signed product.
    logic [2*XLEN-1:0] fast_a, fast_b;
    always_comb begin
        fast_a    = {{XLEN{sgn_a & bus.op_a_i[XLEN-1]}}, bus.op_a_i};
        fast_b    = {{XLEN{sgn_b & bus.op_b_i[XLEN-1]}}, bus.op_b_i};
        fast_prod = fast_a * fast_b;
        fast_mul  = ~is_div;
    end
`else
    always_comb begin
        fast_prod = '0;
        fast_mul  = 1'b0;
    end
`endif

    // hi:lo is the product accumulator for multiplies and remainder:quotient for divides.
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_next, lo_next;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, m};
        div_ge    = div_shift >= {1'b0, m};
        if (func3_q[2]) begin
            hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        prod_fix = neg_q ? ('0 - {hi, lo}) : {hi, lo};
        quo_fix  = neg_q ? ('0 - lo) : lo;
        rem_fix  = neg_r ? ('0 - hi) : hi;
        case (func3_q)
            3'b000:                final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        final_res = quo_fix;
            default:               final_res = rem_fix;
        endcase
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = (state == DONE) & ~bus.flush_i;
    assign bus.result_o = bus.done_o ? final_res : result_q;
    assign bus.stall_o  = bus.start_i & ~bus.done_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            func3_q  <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        func3_q <= bus.func3_i;
                        count   <= CW'(XLEN - 1);
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        // Fast-path results are loaded pre-corrected so DONE needs no special case.
                        if (div_zero) begin
                            hi    <= bus.op_a_i;
                            lo    <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DONE;
                        end else if (div_ovf) begin
                            hi    <= '0;
                            lo    <= {1'b1, {(XLEN-1){1'b0}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DONE;
                        end else if (fast_mul) begin
                            {hi, lo} <= fast_prod;
                            neg_q    <= 1'b0;
                            neg_r    <= 1'b0;
                            state    <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= is_div ? a_abs : b_abs;
                            m     <= is_div ? b_abs : a_abs;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        hi    <= hi_next;
                        lo    <= lo_next;
                        count <= count - 1'b1;
                        if (count == '0) state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.flush_i) result_q <= final_res;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
